// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one round per clock over a single 128-bit state register.
// Accept-to-out_valid is Nr cycles; out_valid holds in DONE until out_ready, and in_ready is low until then.

module aes_sub_bytes (
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // Entry a sits (255-a) bytes up from bit 0, and 255-a is simply ~a.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign q_o[8*i +: 8] = SBOX[{~d_i[8*i +: 8], 3'b000} +: 8];
  end
endmodule

module aes_shift_rows (
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  // Byte n = column n/4, row n%4; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign q_o[127-8*(4*c+r) -: 8] = d_i[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module aes_mix_columns (
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = d_i[127-32*c -: 8];
    assign a1 = d_i[119-32*c -: 8];
    assign a2 = d_i[111-32*c -: 8];
    assign a3 = d_i[103-32*c -: 8];
    assign q_o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  end
endmodule

module aes_add_round_key (
  input  logic [127:0] d_i,
  input  logic [127:0] k_i,
  output logic [127:0] q_o
);
  assign q_o = d_i ^ k_i;
endmodule

module aes_cipher_iter #(
  parameter  int Nk = 4,
  localparam int Nr = Nk + 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           init,
  input  logic [128*(Nr+1)-1:0]  w,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           Encrypted_Msg,
  output logic                   busy
);
  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_cipher_iter: Nk must be 4, 6 or 8");
  end

  localparam logic [3:0] NR4 = 4'(Nr);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [10:0]  key_idx;
  logic [127:0] round_key, sb_out, sr_out, mc_out, ark_in, ark_out;

  // Key schedule is read live; IDLE always selects round key 0 for the whitening step.
  assign key_idx   = (fsm_q == ROUND) ? {rnd_q, 7'd0} : 11'd0;
  assign round_key = w[key_idx +: 128];
  assign ark_in    = (fsm_q != ROUND) ? init : ((rnd_q == NR4) ? sr_out : mc_out);

  aes_sub_bytes     u_sb  (.d_i(state_q), .q_o(sb_out));
  aes_shift_rows    u_sr  (.d_i(sb_out),  .q_o(sr_out));
  aes_mix_columns   u_mc  (.d_i(sr_out),  .q_o(mc_out));
  aes_add_round_key u_ark (.d_i(ark_in),  .k_i(round_key), .q_o(ark_out));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          state_d = ark_out;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        state_d = ark_out;
        if (rnd_q == NR4) fsm_d = DONE;
        else              rnd_d = rnd_q + 4'd1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign Encrypted_Msg = state_q;

endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
- Iterative AES encryption core. Executes one AES round per clock over a single 128-bit state register instead of unrolling all rounds.
- Key size is parametrised through Nk (AES-128/192/256).
- Valid/ready handshakes on both input and output, with output backpressure.
- Sits between the SPI receive path and key expansion on one side and the SPI transmit path on the other.
- Reuses the existing SubBytes, ShiftRows, MixColumns and AddRoundKey combinational modules, one instance each.

Parameters:
- Nk, 4: key length in 32-bit words. Legal values are 4, 6, 8; any other value is an elaboration error.
- Nr, Nk+6: round count. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  plaintext and key schedule presented
- in_ready  output  1  core idle, can accept
- init  input  128  plaintext block, bit 0 = MSB of byte 0 (FIPS-197 order)
- w  input  128*(Nr+1)  expanded key schedule, round r key at w[r*128 +: 128]
- out_valid  output  1  Encrypted_Msg holds a finished ciphertext
- out_ready  input  1  consumer accepts ciphertext
- Encrypted_Msg  output  128  ciphertext, driven directly from the state register
- busy  output  1  high while rounds are in progress

Behaviour:
- Reset (async, active-high): FSM=IDLE, state=0, rnd=0, out_valid=0, busy=0, in_ready=1 once rst deasserts. Reset mid-operation discards the block; no partial result is ever presented.
- FSM states are IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: state <= init XOR w[0:127], rnd <= 1, go to ROUND.
  - init is sampled only on this edge.
- ROUND:
  - in_ready=0, busy=1.
  - Each edge with rnd<Nr: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), w[rnd*128 +: 128]), rnd <= rnd+1.
  - Edge with rnd==Nr: MixColumns bypassed. state <= AddRoundKey(ShiftRows(SubBytes(state)), w[Nr*128 +: 128]), go to DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - Encrypted_Msg is stable while out_valid=1.
  - On an edge with out_ready=1: out_valid <= 0, go to IDLE.
  - out_ready=0 holds DONE indefinitely.
  - Encrypted_Msg keeps its last ciphertext after leaving DONE, until the next accept overwrites it.
- Latency and throughput:
  - Input accepted on edge T gives out_valid=1 after edge T+Nr: 10/12/14 cycles for Nk=4/6/8.
  - Minimum accept-to-accept spacing is Nr+2 cycles when out_ready is held at 1.
- w is sampled live every round. The producer must hold w stable from the accept edge until out_valid rises. No copy of w is registered.
- Width rules:
  - rnd is 4 bits, sufficient for Nr≤14.
  - Round-key slice index is rnd*128, computed in at least 11 bits.
- Boundary cases:
  - in_valid while not in IDLE: ignored, no accept.
  - out_ready while not in DONE: ignored.
  - in_valid and out_ready both high in DONE: only the output handshake completes. The input is accepted on the next cycle, from IDLE.
  - X on init or w while in IDLE with in_valid=0: no effect on state.

Test Plan:
- Nk=4, init=00112233445566778899aabbccddeeff, w=expansion of key 000102…0f -> out_valid rises 10 cycles after accept, Encrypted_Msg=69c4e0d86a7b0430d8cdb78070b4c55a.
- Nk=6, same init, key 000102…17 -> 12 cycles, Encrypted_Msg=dda97ca4864cdfe06eaf70a0ec0d7191.
- Nk=8, same init, key 000102…1f -> 14 cycles, Encrypted_Msg=8ea2b7ca516745bfeafc49904b496089.
- Nk=4, init=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, out_ready held 0 for 20 cycles -> Encrypted_Msg=3925841d02dc09fbdc118597196a0b32 stable throughout, in_ready=0. Releasing out_ready returns the core to IDLE. A second block issued back-to-back is accepted exactly Nr+2 cycles after the first.
- Assert rst at rnd=5 of an AES-128 run -> busy, out_valid and Encrypted_Msg go to 0 asynchronously, with no out_valid pulse. A fresh block after reset gives the correct FIPS vector.
- Toggle in_valid with random init during ROUND and DONE -> no extra accepts, and the ciphertext matches the originally accepted block.
